// File: rtl/vcache_stat_collector.sv
// Per-bank saturating load/store/miss counters with a snapshot-and-drain record stream.
// First record appears one cycle after a snapshot is taken; each record holds until out_yumi_i and snapshots are refused while draining.
module vcache_stat_collector #(
    parameter int num_banks_p        = 8,
    parameter int ctr_width_p        = 32,
    parameter int tag_width_p        = 32,
    parameter int global_ctr_width_p = 32,
    parameter bit clear_on_snap_p    = 1'b0,
    localparam int bank_id_width_lp  = (num_banks_p > 1) ? $clog2(num_banks_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [num_banks_p-1:0]        v_i,
    input  logic [num_banks_p-1:0]        yumi_i,
    input  logic [num_banks_p-1:0]        ld_op_i,
    input  logic [num_banks_p-1:0]        st_op_i,
    input  logic [num_banks_p-1:0]        miss_i,
    input  logic                          clear_i,
    input  logic                          snap_v_i,
    input  logic [tag_width_p-1:0]        snap_tag_i,
    input  logic [global_ctr_width_p-1:0] global_ctr_i,
    output logic                          snap_ready_o,
    output logic                          out_v_o,
    input  logic                          out_yumi_i,
    output logic [bank_id_width_lp-1:0]   out_bank_o,
    output logic [tag_width_p-1:0]        out_tag_o,
    output logic [global_ctr_width_p-1:0] out_global_ctr_o,
    output logic [ctr_width_p-1:0]        out_ld_o,
    output logic [ctr_width_p-1:0]        out_st_o,
    output logic [ctr_width_p-1:0]        out_ld_miss_o,
    output logic [ctr_width_p-1:0]        out_st_miss_o,
    output logic                          out_ovf_o
);

    // counter class index: 0 load, 1 store, 2 load miss, 3 store miss
    typedef enum logic {IDLE, DRAIN} state_e;

    state_e                        state_r, state_n;
    logic [bank_id_width_lp-1:0]   idx_r, idx_n;
    logic                          snap_take;
    logic                          last_rec;

    logic [ctr_width_p-1:0]        live_r [num_banks_p][4];
    logic [ctr_width_p-1:0]        shd_r  [num_banks_p][4];
    logic [num_banks_p-1:0]        ovf_r, shd_ovf_r;
    logic [3:0]                    ev     [num_banks_p];
    logic [3:0]                    sat    [num_banks_p];
    logic [tag_width_p-1:0]        tag_r;
    logic [global_ctr_width_p-1:0] gctr_r;

    assign snap_take = (state_r == IDLE) && snap_v_i;
    assign last_rec  = (idx_r == bank_id_width_lp'(num_banks_p - 1));

    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        case (state_r)
            IDLE: begin
                if (snap_v_i) begin
                    state_n = DRAIN;
                    idx_n   = '0;
                end
            end
            DRAIN: begin
                if (out_yumi_i) begin
                    if (last_rec) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_r + bank_id_width_lp'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    always_comb begin
        for (int b = 0; b < num_banks_p; b++) begin
            ev[b][0] = v_i[b] & yumi_i[b] & ld_op_i[b];
            ev[b][1] = v_i[b] & yumi_i[b] & st_op_i[b];
            ev[b][2] = v_i[b] & yumi_i[b] & ld_op_i[b] & miss_i[b];
            ev[b][3] = v_i[b] & yumi_i[b] & st_op_i[b] & miss_i[b];
            for (int c = 0; c < 4; c++) begin
                sat[b][c] = &live_r[b][c];
            end
        end
    end

    // Shadow captures the pre-update live values; clear beats both events and delta restart.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int b = 0; b < num_banks_p; b++) begin
                for (int c = 0; c < 4; c++) begin
                    live_r[b][c] <= '0;
                    shd_r[b][c]  <= '0;
                end
            end
            ovf_r     <= '0;
            shd_ovf_r <= '0;
            tag_r     <= '0;
            gctr_r    <= '0;
        end else begin
            if (snap_take) begin
                tag_r     <= snap_tag_i;
                gctr_r    <= global_ctr_i;
                shd_ovf_r <= ovf_r;
            end
            for (int b = 0; b < num_banks_p; b++) begin
                if (snap_take) begin
                    for (int c = 0; c < 4; c++) begin
                        shd_r[b][c] <= live_r[b][c];
                    end
                end
                if (clear_i) begin
                    for (int c = 0; c < 4; c++) begin
                        live_r[b][c] <= '0;
                    end
                    ovf_r[b] <= 1'b0;
                end else if (snap_take && clear_on_snap_p) begin
                    for (int c = 0; c < 4; c++) begin
                        live_r[b][c] <= ctr_width_p'(ev[b][c]);
                    end
                    ovf_r[b] <= 1'b0;
                end else begin
                    for (int c = 0; c < 4; c++) begin
                        if (ev[b][c] && !sat[b][c]) begin
                            live_r[b][c] <= live_r[b][c] + ctr_width_p'(1);
                        end
                    end
                    if (|(ev[b] & sat[b])) begin
                        ovf_r[b] <= 1'b1;
                    end
                end
            end
        end
    end

    assign snap_ready_o     = (state_r == IDLE);
    assign out_v_o          = (state_r == DRAIN);
    assign out_bank_o       = idx_r;
    assign out_tag_o        = tag_r;
    assign out_global_ctr_o = gctr_r;
    assign out_ld_o         = shd_r[idx_r][0];
    assign out_st_o         = shd_r[idx_r][1];
    assign out_ld_miss_o    = shd_r[idx_r][2];
    assign out_st_miss_o    = shd_r[idx_r][3];
    assign out_ovf_o        = shd_ovf_r[idx_r];

    out_yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) out_yumi_i |-> out_v_o);

endmodule

// File: tb/tb_vcache_stat_collector.sv
// Drives three collector configurations (cumulative 32-bit, cumulative 4-bit, delta 32-bit) with shared
// stimulus and compares every record against per-configuration count arrays kept by the bench.
module tb_vcache_stat_collector;
    localparam int NB = 8;

    typedef struct packed {
        logic        v;
        logic        rdy;
        logic [2:0]  bank;
        logic [31:0] tag;
        logic [31:0] gc;
        logic [31:0] ld;
        logic [31:0] st;
        logic [31:0] ldm;
        logic [31:0] stm;
        logic        ovf;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [NB-1:0] v, yumi, ld_op, st_op, miss;
    logic          clear, snap_v, out_yumi;
    logic [31:0]   tag, gc;

    logic          a_v, a_rdy, a_ovf, s_v, s_rdy, s_ovf, c_v, c_rdy, c_ovf;
    logic [2:0]    a_bank, s_bank, c_bank;
    logic [31:0]   a_tag, a_gc, a_ld, a_st, a_ldm, a_stm;
    logic [31:0]   s_tag, s_gc, c_tag, c_gc, c_ld, c_st, c_ldm, c_stm;
    logic [3:0]    s_ld, s_st, s_ldm, s_stm;
    rec_t          obs [3];

    vcache_stat_collector dut_cum (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .yumi_i(yumi), .ld_op_i(ld_op), .st_op_i(st_op),
        .miss_i(miss), .clear_i(clear), .snap_v_i(snap_v), .snap_tag_i(tag), .global_ctr_i(gc),
        .snap_ready_o(a_rdy), .out_v_o(a_v), .out_yumi_i(out_yumi), .out_bank_o(a_bank), .out_tag_o(a_tag),
        .out_global_ctr_o(a_gc), .out_ld_o(a_ld), .out_st_o(a_st), .out_ld_miss_o(a_ldm),
        .out_st_miss_o(a_stm), .out_ovf_o(a_ovf));

    vcache_stat_collector #(.ctr_width_p(4)) dut_sat (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .yumi_i(yumi), .ld_op_i(ld_op), .st_op_i(st_op),
        .miss_i(miss), .clear_i(clear), .snap_v_i(snap_v), .snap_tag_i(tag), .global_ctr_i(gc),
        .snap_ready_o(s_rdy), .out_v_o(s_v), .out_yumi_i(out_yumi), .out_bank_o(s_bank), .out_tag_o(s_tag),
        .out_global_ctr_o(s_gc), .out_ld_o(s_ld), .out_st_o(s_st), .out_ld_miss_o(s_ldm),
        .out_st_miss_o(s_stm), .out_ovf_o(s_ovf));

    vcache_stat_collector #(.clear_on_snap_p(1'b1)) dut_cos (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .yumi_i(yumi), .ld_op_i(ld_op), .st_op_i(st_op),
        .miss_i(miss), .clear_i(clear), .snap_v_i(snap_v), .snap_tag_i(tag), .global_ctr_i(gc),
        .snap_ready_o(c_rdy), .out_v_o(c_v), .out_yumi_i(out_yumi), .out_bank_o(c_bank), .out_tag_o(c_tag),
        .out_global_ctr_o(c_gc), .out_ld_o(c_ld), .out_st_o(c_st), .out_ld_miss_o(c_ldm),
        .out_st_miss_o(c_stm), .out_ovf_o(c_ovf));

    assign obs[0] = {a_v, a_rdy, a_bank, a_tag, a_gc, a_ld, a_st, a_ldm, a_stm, a_ovf};
    assign obs[1] = {s_v, s_rdy, s_bank, s_tag, s_gc, 28'd0, s_ld, 28'd0, s_st, 28'd0, s_ldm, 28'd0, s_stm, s_ovf};
    assign obs[2] = {c_v, c_rdy, c_bank, c_tag, c_gc, c_ld, c_st, c_ldm, c_stm, c_ovf};

    // Reference state: live and snapshotted counts per configuration, bank and event class.
    longint unsigned m_cnt [3][NB][4];
    longint unsigned m_shd [3][NB][4];
    bit              m_ovf [3][NB];
    bit              m_shovf [3][NB];
    bit              m_busy;
    int              m_idx;
    logic [31:0]     m_tag, m_gc;
    int              errors = 0;
    int              checks = 0;

    function automatic longint unsigned cmax(input int k);
        return (k == 1) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    task automatic model_tick();
        bit take;
        bit [3:0] e;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++)
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < 4; c++) begin m_cnt[k][b][c] = 0; m_shd[k][b][c] = 0; end
                    m_ovf[k][b] = 0; m_shovf[k][b] = 0;
                end
            m_busy = 0; m_idx = 0; m_tag = '0; m_gc = '0;
            return;
        end
        take = snap_v && !m_busy;
        if (take) begin
            m_shd = m_cnt; m_shovf = m_ovf; m_tag = tag; m_gc = gc; m_busy = 1; m_idx = 0;
        end else if (m_busy && out_yumi) begin
            m_idx++;
            if (m_idx == NB) begin m_busy = 0; m_idx = 0; end
        end
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < NB; b++) begin
                e[0] = v[b] & yumi[b] & ld_op[b];
                e[1] = v[b] & yumi[b] & st_op[b];
                e[2] = e[0] & miss[b];
                e[3] = e[1] & miss[b];
                if (clear) begin
                    for (int c = 0; c < 4; c++) m_cnt[k][b][c] = 0;
                    m_ovf[k][b] = 0;
                end else if (take && k == 2) begin
                    for (int c = 0; c < 4; c++) m_cnt[k][b][c] = e[c];
                    m_ovf[k][b] = 0;
                end else begin
                    for (int c = 0; c < 4; c++)
                        if (e[c]) begin
                            if (m_cnt[k][b][c] == cmax(k)) m_ovf[k][b] = 1;
                            else m_cnt[k][b][c]++;
                        end
                end
            end
    endtask

    function automatic rec_t exp_rec(input int k);
        rec_t r;
        r.v = m_busy; r.rdy = !m_busy; r.bank = 3'(m_idx); r.tag = m_tag; r.gc = m_gc;
        r.ld = 32'(m_shd[k][m_idx][0]); r.st = 32'(m_shd[k][m_idx][1]);
        r.ldm = 32'(m_shd[k][m_idx][2]); r.stm = 32'(m_shd[k][m_idx][3]);
        r.ovf = m_shovf[k][m_idx];
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
        gc = gc + 32'd1;
    endtask

    task automatic drive_ev(input int b, input bit l, input bit s, input bit ms);
        v[b] = 1'b1; yumi[b] = 1'b1; ld_op[b] = l; st_op[b] = s; miss[b] = ms;
        cycle();
        v = '0; yumi = '0; ld_op = '0; st_op = '0; miss = '0;
    endtask

    task automatic test_reset();
        rec_t z;
        z = '0; z.rdy = 1'b1;
        reset_n = 1'b0; cycle(); cycle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== z) begin errors++; $display("FAIL reset_state dut%0d got=%h exp=%h", k, obs[k], z); end
        end
        reset_n = 1'b1; cycle();
        snap_v = 1'b1; tag = 32'hA5; cycle(); snap_v = 1'b0;
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_rec(k) || obs[k].tag !== 32'hA5 || obs[k].ld !== 32'd0 || obs[k].rdy !== 1'b0) begin
                    errors++; $display("FAIL reset_snap dut%0d rec%0d got=%h exp=%h", k, i, obs[k], exp_rec(k));
                end
            end
            out_yumi = 1'b1; cycle(); out_yumi = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k].v !== 1'b0 || obs[k].rdy !== 1'b1) begin
                errors++; $display("FAIL reset_snap_end dut%0d got v=%b rdy=%b exp v=0 rdy=1", k, obs[k].v, obs[k].rdy);
            end
        end
    endtask

    task automatic test_bank3();
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int i = 0; i < 5; i++) drive_ev(3, 1'b1, 1'b0, i < 2);
        for (int i = 0; i < 3; i++) drive_ev(3, 1'b0, 1'b1, i == 0);
        v[3] = 1'b1; ld_op[3] = 1'b1; cycle(); v = '0; ld_op = '0;
        snap_v = 1'b1; tag = 32'h33; cycle(); snap_v = 1'b0;
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_rec(k)) begin
                    errors++; $display("FAIL bank3_rec dut%0d rec%0d got=%h exp=%h", k, i, obs[k], exp_rec(k));
                end
            end
            if (i == 3) begin
                checks++;
                if ({obs[0].ld, obs[0].st, obs[0].ldm, obs[0].stm} !== {32'd5, 32'd3, 32'd2, 32'd1}) begin
                    errors++; $display("FAIL bank3_counts got ld=%0d st=%0d ldm=%0d stm=%0d exp 5 3 2 1",
                                       obs[0].ld, obs[0].st, obs[0].ldm, obs[0].stm);
                end
            end
            out_yumi = 1'b1; cycle(); out_yumi = 1'b0;
        end
    endtask

    task automatic test_saturation();
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int i = 0; i < 17; i++) drive_ev(0, 1'b1, 1'b0, 1'b0);
        snap_v = 1'b1; tag = 32'h51; cycle(); snap_v = 1'b0;
        checks++;
        if (obs[1].ld !== 32'd15 || obs[1].ovf !== 1'b1 || obs[0].ld !== 32'd17 || obs[0].ovf !== 1'b0) begin
            errors++; $display("FAIL sat_hold got sat ld=%0d ovf=%b cum ld=%0d ovf=%b exp 15 1 17 0",
                               obs[1].ld, obs[1].ovf, obs[0].ld, obs[0].ovf);
        end
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_rec(k)) begin
                    errors++; $display("FAIL sat_rec dut%0d rec%0d got=%h exp=%h", k, i, obs[k], exp_rec(k));
                end
            end
            out_yumi = 1'b1; cycle(); out_yumi = 1'b0;
        end
        clear = 1'b1; cycle(); clear = 1'b0;
        drive_ev(0, 1'b1, 1'b0, 1'b0);
        snap_v = 1'b1; tag = 32'h52; cycle(); snap_v = 1'b0;
        checks++;
        if (obs[1].ld !== 32'd1 || obs[1].ovf !== 1'b0) begin
            errors++; $display("FAIL sat_clear got ld=%0d ovf=%b exp ld=1 ovf=0", obs[1].ld, obs[1].ovf);
        end
        for (int i = 0; i < NB; i++) begin out_yumi = 1'b1; cycle(); out_yumi = 1'b0; end
    endtask

    task automatic test_clear_on_snap();
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int i = 0; i < 4; i++) drive_ev(0, 1'b1, 1'b0, 1'b0);
        snap_v = 1'b1; tag = 32'hC0; drive_ev(0, 1'b1, 1'b0, 1'b0); snap_v = 1'b0;
        checks++;
        if (obs[2].ld !== 32'd4 || obs[0].ld !== 32'd4) begin
            errors++; $display("FAIL cos_first got delta=%0d cum=%0d exp 4 4", obs[2].ld, obs[0].ld);
        end
        for (int i = 0; i < NB; i++) begin out_yumi = 1'b1; cycle(); out_yumi = 1'b0; end
        for (int i = 0; i < 2; i++) drive_ev(0, 1'b1, 1'b0, 1'b0);
        snap_v = 1'b1; tag = 32'hC1; cycle(); snap_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== exp_rec(k)) begin errors++; $display("FAIL cos_rec dut%0d got=%h exp=%h", k, obs[k], exp_rec(k)); end
        end
        checks++;
        if (obs[2].ld !== 32'd3 || obs[0].ld !== 32'd7) begin
            errors++; $display("FAIL cos_second got delta=%0d cum=%0d exp 3 7", obs[2].ld, obs[0].ld);
        end
        for (int i = 0; i < NB; i++) begin out_yumi = 1'b1; cycle(); out_yumi = 1'b0; end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) drive_ev($urandom_range(0, NB-1), 1'($urandom), 1'($urandom), 1'($urandom));
        snap_v = 1'b1; tag = 32'h1234; cycle(); snap_v = 1'b0;
        for (int i = 0; i < 2; i++) begin out_yumi = 1'b1; cycle(); out_yumi = 1'b0; end
        for (int t = 0; t < 10; t++) begin
            snap_v = 1'b1; tag = 32'hDEAD_0000 + 32'(t);
            v = 8'($urandom); yumi = 8'($urandom); ld_op = 8'($urandom);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_rec(k) || obs[k].bank !== 3'd2 || obs[k].tag !== 32'h1234) begin
                    errors++; $display("FAIL bp_hold dut%0d t=%0d got=%h exp=%h", k, t, obs[k], exp_rec(k));
                end
            end
            cycle();
        end
        snap_v = 1'b0; v = '0; yumi = '0; ld_op = '0;
        for (int i = 2; i < NB; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_rec(k)) begin errors++; $display("FAIL bp_rec dut%0d rec%0d got=%h exp=%h", k, i, obs[k], exp_rec(k)); end
            end
            out_yumi = 1'b1; cycle(); out_yumi = 1'b0;
        end
        snap_v = 1'b1; tag = 32'h77; cycle(); snap_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k].v !== 1'b1 || obs[k].tag !== 32'h77 || obs[k] !== exp_rec(k)) begin
                errors++; $display("FAIL bp_resnap dut%0d got=%h exp=%h", k, obs[k], exp_rec(k));
            end
        end
        for (int i = 0; i < NB; i++) begin out_yumi = 1'b1; cycle(); out_yumi = 1'b0; end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 5; i++) drive_ev(i, 1'b1, 1'b1, 1'b1);
        snap_v = 1'b1; tag = 32'h44; cycle(); snap_v = 1'b0;
        for (int i = 0; i < 4; i++) begin out_yumi = 1'b1; cycle(); out_yumi = 1'b0; end
        reset_n = 1'b0; cycle(); reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k].v !== 1'b0 || obs[k].rdy !== 1'b1) begin
                errors++; $display("FAIL mid_reset dut%0d got v=%b rdy=%b exp v=0 rdy=1", k, obs[k].v, obs[k].rdy);
            end
        end
        snap_v = 1'b1; tag = 32'h45; cycle(); snap_v = 1'b0;
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_rec(k) || {obs[k].ld, obs[k].st, obs[k].ldm, obs[k].stm, obs[k].ovf} !== '0) begin
                    errors++; $display("FAIL mid_reset_rec dut%0d rec%0d got=%h exp=%h", k, i, obs[k], exp_rec(k));
                end
            end
            out_yumi = 1'b1; cycle(); out_yumi = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset_n  = ($urandom_range(0, 599) != 0);
            v        = 8'($urandom); yumi = 8'($urandom);
            ld_op    = 8'($urandom); st_op = 8'($urandom); miss = 8'($urandom);
            clear    = ($urandom_range(0, 63) == 0);
            snap_v   = ($urandom_range(0, 7) == 0);
            tag      = $urandom;
            out_yumi = m_busy && ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (m_busy ? (obs[k] !== exp_rec(k)) : ({obs[k].v, obs[k].rdy} !== 2'b01)) begin
                    errors++; $display("FAIL random dut%0d n=%0d got=%h exp=%h", k, n, obs[k], exp_rec(k));
                end
            end
            cycle();
        end
        reset_n = 1'b1; v = '0; yumi = '0; ld_op = '0; st_op = '0; miss = '0;
        clear = 1'b0; snap_v = 1'b0; out_yumi = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; v = '0; yumi = '0; ld_op = '0; st_op = '0; miss = '0;
        clear = 1'b0; snap_v = 1'b0; out_yumi = 1'b0; tag = '0; gc = 32'h100;
        test_reset();
        test_bank3();
        test_saturation();
        test_clear_on_snap();
        test_backpressure();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vcache_stat_collector.md
Name: vcache_stat_collector

Overview:
- Synthesizable, multi-bank statistics collector for the vcache array. Sits beside the vcache banks and observes each bank's response handshake.
- Keeps saturating per-bank counters for four event classes: loads, stores, load misses and store misses.
- On request, snapshots every bank's counters and streams one record per bank over a valid/yumi port to a host-visible packetizer.
- Supports cumulative mode and delta mode (counters cleared on snapshot).

Parameters:
- num_banks_p, 8, number of vcache banks observed (>=1).
- ctr_width_p, 32, width of each event counter.
- tag_width_p, 32, width of the snapshot tag.
- global_ctr_width_p, 32, width of the global cycle counter.
- clear_on_snap_p, 0, 0 = cumulative mode; 1 = delta mode, live counters restart on each snapshot.
- bank_id_width_lp, `BSG_SAFE_CLOG2(num_banks_p), derived width of the bank index.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous reset, active-low.
- v_i  in  num_banks_p  per-bank response valid.
- yumi_i  in  num_banks_p  per-bank response accepted.
- ld_op_i  in  num_banks_p  per-bank decoded load op.
- st_op_i  in  num_banks_p  per-bank decoded store op.
- miss_i  in  num_banks_p  per-bank miss indication.
- clear_i  in  1  zero live counters and overflow flags.
- snap_v_i  in  1  snapshot request.
- snap_tag_i  in  tag_width_p  tag attached to the snapshot.
- global_ctr_i  in  global_ctr_width_p  global cycle counter.
- snap_ready_o  out  1  collector idle; snapshot request will be taken.
- out_v_o  out  1  record valid.
- out_yumi_i  in  1  record consumed.
- out_bank_o  out  bank_id_width_lp  bank index of the record.
- out_tag_o  out  tag_width_p  latched snapshot tag.
- out_global_ctr_o  out  global_ctr_width_p  global_ctr_i latched at snapshot.
- out_ld_o, out_st_o, out_ld_miss_o, out_st_miss_o  out  ctr_width_p each  snapshotted counts.
- out_ovf_o  out  1  sticky saturation flag of this bank at snapshot.

Behaviour:
- Reset (reset_n_i==0 at posedge):
  - state=IDLE; all live counters, shadow counters and overflow flags = 0.
  - out_v_o=0, snap_ready_o=1 in the next cycle; out_* data = 0.
- Event decode per bank b:
  - fire = v_i[b] & yumi_i[b].
  - ld = fire & ld_op_i[b]; st = fire & st_op_i[b].
  - ld_miss = ld & miss_i[b]; st_miss = st & miss_i[b].
  - ld_op_i and st_op_i both set: both classes count.
- Counters:
  - Each increments by 1 on its event at posedge.
  - At all-ones, a counter holds (saturates) and sets that bank's sticky ovf flag on any further event.
- clear_i: at posedge, live counters and ovf = 0. Clear wins over same-cycle events (those events are lost).
- State machine, two states IDLE / DRAIN; snap_ready_o = (state==IDLE).
  - IDLE with snap_v_i:
    - Shadow registers capture the live counters and ovf flags as they were before this cycle's increments/clear.
    - Tag and global_ctr_i are latched; bank index = 0; go to DRAIN.
    - If clear_on_snap_p=1: live counters and ovf restart, with this cycle's events counted (value 0 or 1).
    - With clear_i in the same cycle: snapshot sees pre-clear values, then live counters clear.
  - DRAIN:
    - out_v_o=1; outputs present shadow[index]; data held stable until out_yumi_i.
    - On out_yumi_i: index+1. On yumi with index==num_banks_p-1: go to IDLE, out_v_o=0 next cycle.
    - First record is valid the cycle after the snapshot is accepted. Drain takes num_banks_p cycles minimum.
  - snap_v_i while in DRAIN is ignored (no queueing). Live counting continues in all states.
- out_yumi_i while out_v_o=0: ignored (protocol violation; assert in simulation).
- Reset mid-drain: state forced to IDLE, record stream aborted, all counters zeroed.
- Width rules: all counters unsigned. out_bank_o is index zero-extended. num_banks_p=1 uses a 1-bit index, always 0.

Test Plan:
- Reset then snapshot: snap_v_i=1, tag=0xA5 -> 8 records, bank 0..7, all counts 0, ovf=0, out_tag_o=0xA5, snap_ready_o=0 until last yumi.
- Bank 3: 5 loads (2 missing), 3 stores (1 missing); snapshot -> bank 3 record ld=5, st=3, ld_miss=2, st_miss=1; other banks 0.
- ctr_width_p=4: 17 loads on bank 0 -> ld=15, ovf=1. clear_i then 1 load, snapshot -> ld=1, ovf=0.
- clear_on_snap_p=1: 4 loads, snapshot in the same cycle as 1 load, then 2 loads, second snapshot -> first record ld=4, second ld=3. Cumulative mode (0), same stimulus -> 4, then 7.
- Backpressure: hold out_yumi_i=0 for 10 cycles on bank 2 -> outputs stable. snap_v_i during drain -> ignored; after drain one new snapshot accepted.
- reset_n_i=0 during bank-4 record -> out_v_o=0 next cycle, snap_ready_o=1. Following snapshot -> all zeros.
